// File: rtl/lutram_mp.sv
// lutram_mp: DEPTH x WIDTH distributed RAM with byte-enable write, NRD combinational read ports
// and a self-clearing sweep after reset or clr. Define LUTRAM_MP_BYPASS_EN for write-to-read forwarding.
module lutram_mp #(
   parameter int               WIDTH      = 128,
   parameter int               DEPTH      = 128,
   parameter int               ADDRW      = $clog2(DEPTH),
   parameter int               NRD        = 2,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   output logic                 busy,
   input  logic                 we,
   input  logic [WIDTH/8-1:0]   be,
   input  logic [ADDRW-1:0]     wa,
   input  logic [WIDTH-1:0]     wd,
   input  logic [NRD*ADDRW-1:0] ra,
   output logic [NRD*WIDTH-1:0] rd
);
   localparam int               NB       = WIDTH / 8;
   localparam int               AW1      = ADDRW + 1;
   localparam logic [ADDRW:0]   DEPTH_W  = AW1'(DEPTH);
   localparam logic [ADDRW-1:0] LAST_PTR = ADDRW'(DEPTH - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t           state_q, state_d;
   logic [ADDRW-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             wa_ok, mem_we;
   logic [ADDRW-1:0] wa_safe, mem_wa;
   logic [WIDTH-1:0] merged, mem_wd;

   assign busy    = (state_q == CLEAR);
   assign wa_ok   = ({1'b0, wa} < DEPTH_W);
   assign wa_safe = wa_ok ? wa : '0;

   // Read-modify-write word: new bytes where be is set, current contents elsewhere.
   always_comb begin
      merged = mem_q[wa_safe];
      for (int i = 0; i < NB; i++)
         if (be[i]) merged[i*8 +: 8] = wd[i*8 +: 8];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mem_we  = 1'b0;
      mem_wa  = wa_safe;
      mem_wd  = merged;
      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            mem_wa = ptr_q;
            mem_wd = INIT_VALUE;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         default: begin
            // A user write coincident with clr still lands; the sweep starts next cycle.
            mem_we = we && wa_ok && (|be);
            if (clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDRW-1:0] a;
      logic             a_ok;
      logic [WIDTH-1:0] q;

      assign a    = ra[k*ADDRW +: ADDRW];
      assign a_ok = ({1'b0, a} < DEPTH_W);

      always_comb begin
         q = '0;
         if (busy)      q = INIT_VALUE;
         else if (a_ok) q = mem_q[a];
`ifdef LUTRAM_MP_BYPASS_EN
         if (!busy && a_ok && we && (a == wa)) q = merged;
`endif
      end

      assign rd[k*WIDTH +: WIDTH] = q;
   end

endmodule

// File: tb/tb_lutram_mp.sv
// tb_lutram_mp: scoreboard bench for lutram_mp; a 128-deep 2-port instance and a 100-deep 1-port
// instance with non-zero INIT_VALUE share clock, reset, clr and the write port.
module tb_lutram_mp;
   localparam int            W     = 128;
   localparam int            D     = 128;
   localparam int            D2    = 100;
   localparam int            AW    = 7;
   localparam logic [W-1:0]  INIT2 = {16{8'h3C}};
`ifdef LUTRAM_MP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0, rst = 1'b1, clr = 1'b0, we = 1'b0;
   logic [15:0]   be  = '0;
   logic [AW-1:0] wa  = '0;
   logic [W-1:0]  wd  = '0;
   logic [2*AW-1:0] ra = '0;
   logic [2*W-1:0]  rd;
   logic [AW-1:0] ra2 = '0;
   logic [W-1:0]  rd2;
   logic          busy, busy2;

   always #5 clk = ~clk;

   lutram_mp #(.WIDTH(W), .DEPTH(D), .NRD(2)) dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy), .we(we), .be(be),
      .wa(wa), .wd(wd), .ra(ra), .rd(rd));

   lutram_mp #(.WIDTH(W), .DEPTH(D2), .NRD(1), .INIT_VALUE(INIT2)) dut2 (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy2), .we(we), .be(be),
      .wa(wa), .wd(wd), .ra(ra2), .rd(rd2));

   logic [W-1:0] mdl  [D];
   logic [W-1:0] mdl2 [D2];
   int total = 0, bad = 0;

   typedef struct { string tag; int src; logic [W-1:0] exp; } sb_t;
   sb_t sb_q[$];

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] obs(input int src);
      case (src)
         0:       return rd[0 +: W];
         1:       return rd[W +: W];
         2:       return W'(busy);
         3:       return rd2;
         default: return W'(busy2);
      endcase
   endfunction

   function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] d,
                                          input logic [15:0] m);
      logic [W-1:0] r;
      r = o;
      for (int i = 0; i < 16; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic push(input string tag, input int src, input logic [W-1:0] exp);
      sb_t e;
      e.tag = tag; e.src = src; e.exp = exp;
      sb_q.push_back(e);
   endtask

   // Compare everything queued for this cycle on the falling edge, then move just past the next rise.
   task automatic step();
      sb_t e;
      @(negedge clk);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, obs(e.src), e.exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sweep_models();
      for (int i = 0; i < D; i++)  mdl[i]  = '0;
      for (int i = 0; i < D2; i++) mdl2[i] = INIT2;
   endtask

   // One IDLE cycle: optional write plus reads on all three ports, checked against the models.
   task automatic cyc(input string tag, input logic w, input int a, input logic [W-1:0] d,
                      input logic [15:0] m, input int r0, input int r1, input int r2);
      logic [W-1:0] nw, e2;
      nw = merge(mdl[a], d, m);
      we = w; wa = AW'(a); wd = d; be = m;
      ra = {AW'(r1), AW'(r0)}; ra2 = AW'(r2);
      push({tag, "_rd0"}, 0, (BYP && w && r0 == a) ? nw : mdl[r0]);
      push({tag, "_rd1"}, 1, (BYP && w && r1 == a) ? nw : mdl[r1]);
      if (r2 >= D2)                e2 = '0;
      else if (BYP && w && r2 == a) e2 = merge(mdl2[r2], d, m);
      else                         e2 = mdl2[r2];
      push({tag, "_rd2"}, 3, e2);
      push({tag, "_busy"}, 2, '0);
      push({tag, "_busy2"}, 4, '0);
      step();
      if (w) begin
         mdl[a] = nw;
         if (a < D2) mdl2[a] = merge(mdl2[a], d, m);
      end
      we = 1'b0;
   endtask

   // Checks a sweep already entered on the last edge; optional clr or rst pulse at cycle c.
   task automatic sweep_chk(input string tag, input int rst_at, input int clr_at);
      int s;
      s  = 0;
      we = 1'b1; wa = AW'(127); wd = '1; be = '1;
      ra = {AW'(7), AW'(7)}; ra2 = AW'(7);
      for (int c = 0; s < D; c++) begin
         clr = (c == clr_at);
         if (c == rst_at) begin
            rst = 1'b1; #1; rst = 1'b0;
            s = 0;
         end
         push({tag, "_busy"}, 2, W'(1));
         push({tag, "_busy2"}, 4, W'(s < D2));
         push({tag, "_rd0"}, 0, '0);
         push({tag, "_rd1"}, 1, '0);
         push({tag, "_rd2"}, 3, INIT2);
         step();
         s++;
      end
      clr = 1'b0; we = 1'b0;
      sweep_models();
      push({tag, "_done"}, 2, '0);
      push({tag, "_done2"}, 4, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, r0;
      #2;
      push("rst_busy", 2, W'(1));
      push("rst_busy2", 4, W'(1));
      push("rst_rd0", 0, '0);
      push("rst_rd2", 3, INIT2);
      step();

      // Post-reset sweep with writes hammering throughout.
      rst = 1'b0; we = 1'b1; be = '1; wd = '1;
      for (int c = 0; c < D; c++) begin
         wa = AW'(c); ra = {AW'(c), AW'(D - 1 - c)}; ra2 = AW'(c);
         push("init_busy", 2, W'(1));
         push("init_busy2", 4, W'(c < D2));
         push("init_rd0", 0, '0);
         push("init_rd1", 1, '0);
         push("init_rd2", 3, (c < D2) ? INIT2 : '0);
         step();
      end
      we = 1'b0;
      sweep_models();
      for (int i = 0; i < D; i++) cyc("clean", 1'b0, 0, '0, '0, i, D - 1 - i, i);

      // Byte-enable merge.
      cyc("wr_aa", 1'b1, 5, {16{8'hAA}}, 16'hFFFF, 5, 5, 5);
      cyc("wr_55", 1'b1, 5, {16{8'h55}}, 16'h0001, 5, 4, 5);
      push("merge_const", 0, {{15{8'hAA}}, 8'h55});
      cyc("rd_5", 1'b0, 0, '0, '0, 5, 5, 5);
      cyc("be0", 1'b1, 5, '1, 16'h0000, 5, 5, 5);
      cyc("be0_rd", 1'b0, 0, '0, '0, 5, 5, 5);
      cyc("part", 1'b1, 5, {16{8'h11}}, 16'h00F0, 5, 4, 5);
      cyc("part_rd", 1'b0, 0, '0, '0, 5, 5, 5);

      // Same-cycle read of the address being written on both ports.
      cyc("same3", 1'b1, 3, {8{16'hBEEF}}, 16'hFFFF, 3, 3, 3);
      cyc("same3_nx", 1'b0, 0, '0, '0, 3, 3, 3);

      // Out-of-range write/read on the 100-deep instance.
      cyc("oob_wr", 1'b1, 110, {16{8'hCC}}, 16'hFFFF, 110, 5, 110);
      push("oob_rd2_zero", 3, '0);
      cyc("oob_rd", 1'b0, 0, '0, '0, 110, 99, 110);

      for (int n = 0; n < 40; n++) begin
         a  = int'($urandom_range(0, D - 1));
         r0 = ($urandom_range(0, 1) == 1) ? a : int'($urandom_range(0, D - 1));
         cyc("rnd", 1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
             16'($urandom), r0, a, a);
      end

      // clr mid-sweep is ignored.
      clr = 1'b1;
      cyc("clr_go", 1'b0, 0, '0, '0, 1, 2, 3);
      sweep_chk("clr40", -1, 40);

      // rst mid-sweep restarts the count.
      clr = 1'b1;
      cyc("clr_go2", 1'b0, 0, '0, '0, 1, 2, 3);
      sweep_chk("rst40", 40, -1);

      // clr together with a write: write lands, then the sweep wipes it.
      cyc("pre7", 1'b1, 7, {16{8'h77}}, 16'hFFFF, 7, 7, 7);
      clr = 1'b1;
      cyc("clr_wr7", 1'b1, 7, {16{8'h99}}, 16'hFFFF, 7, 6, 7);
      sweep_chk("clrwr", -1, -1);
      cyc("post7", 1'b0, 0, '0, '0, 7, 7, 7);

      // rst while idle triggers a full sweep.
      cyc("pre9", 1'b1, 9, {16{8'h5A}}, 16'hFFFF, 9, 9, 9);
      cyc("pre9_rd", 1'b0, 0, '0, '0, 9, 9, 9);
      sweep_chk("rstidle", 0, -1);
      cyc("post9", 1'b0, 0, '0, '0, 9, 110, 9);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lutram_mp.md
LUTRAM_MP -- requirements
Module: lutram_mp

Interface
REQ-001 Parameter WIDTH, default 128: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 128: number of entries; any value >= 2, power of two not required.
REQ-003 Parameter ADDRW, default $clog2(DEPTH): address width.
REQ-004 Parameter NRD, default 2: number of independent asynchronous read ports, 1..4.
REQ-005 Parameter INIT_VALUE, default all-zeros WIDTH-bit word: value written to every entry by the clear sweep.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 clr  input  1  single-cycle request to re-run the clear sweep.
REQ-009 busy  output  1  high while the clear sweep is running.
REQ-010 we  input  1  write enable.
REQ-011 be  input  WIDTH/8  byte enables; bit i qualifies wd[8i+7:8i].
REQ-012 wa  input  ADDRW  write address.
REQ-013 wd  input  WIDTH  write data.
REQ-014 ra  input  NRD*ADDRW  read addresses; port k uses ra[k*ADDRW +: ADDRW].
REQ-015 rd  output  NRD*WIDTH  read data; port k drives rd[k*WIDTH +: WIDTH].

Function
REQ-016 Storage SHALL be DEPTH x WIDTH distributed (LUT) RAM, with no reset applied to the array itself.
REQ-017 State machine SHALL have two states, CLEAR and IDLE, plus a sweep pointer ptr of ADDRW bits.
REQ-018 In CLEAR, each cycle SHALL write INIT_VALUE to mem[ptr] and increment ptr; the write to ptr==DEPTH-1 SHALL move to IDLE on that same edge, so a sweep lasts exactly DEPTH cycles.
REQ-019 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-020 In IDLE, clr=1 SHALL enter CLEAR with ptr=0 on the next edge; clr SHALL be ignored in CLEAR (no restart).
REQ-021 If clr and we are both high in IDLE, the user write SHALL complete on that edge and the sweep SHALL start on the following cycle.
REQ-022 In IDLE with we=1, each byte i with be[i]=1 SHALL be written on the rising edge; bytes with be[i]=0 SHALL be preserved.
REQ-023 we SHALL be ignored in CLEAR; we with be all-zero SHALL leave memory unchanged.
REQ-024 Writes with wa >= DEPTH SHALL be discarded.
REQ-025 Each read port SHALL be combinational: rd_k = mem[ra_k], with zero latency.
REQ-026 A read port with ra_k >= DEPTH SHALL return all-zeros.
REQ-027 While busy=1, every read port SHALL return INIT_VALUE, regardless of address.
REQ-028 Any number of read ports MAY address the same entry as each other, or the same entry as wa, in the same cycle.

Reset
REQ-029 Asserting rst SHALL immediately force state=CLEAR, ptr=0, busy=1, independent of clk.
REQ-030 After rst deasserts, the sweep SHALL run DEPTH cycles; busy SHALL fall after the DEPTH-th rising edge.
REQ-031 rst asserted mid-sweep SHALL restart the sweep from ptr=0.
REQ-032 rst asserted mid-IDLE SHALL trigger a full sweep; array contents SHALL become INIT_VALUE once the sweep completes.

Configuration
REQ-033 Macro LUTRAM_MP_BYPASS_EN defined: in IDLE with we=1 and ra_k==wa<DEPTH, rd_k SHALL return the merged word in the same cycle (wd bytes where be=1, old mem bytes elsewhere).
REQ-034 Macro LUTRAM_MP_BYPASS_EN undefined: rd_k SHALL return the old contents in that cycle, and the new data SHALL be visible from the next cycle.

Verification
REQ-035 Pulse rst, then hold we=1 -> busy=1 for exactly 128 cycles (defaults); all rd=0 during that time; writes ignored; afterwards, a read of every address returns 0.
REQ-036 IDLE: write wa=5, wd=all 0xAA, be=all ones; next cycle write wa=5, wd=all 0x55, be=0x0001 -> ra=5 reads 0xAA..AA55.
REQ-037 NRD=2: ra0=3, ra1=3, with wa=3 written in the same cycle -> with bypass, both ports show the new data that cycle; without bypass, both show the old data, then the new data the next cycle.
REQ-038 DEPTH=100: write to wa=110 -> no entry changes; ra=110 reads 0; the sweep lasts 100 cycles.
REQ-039 clr pulsed at sweep cycle 40 -> ignored, busy falls at cycle 128; rst at cycle 40 -> busy stays high 128 more cycles.
REQ-040 IDLE: clr=1 and we=1 to wa=7 in the same cycle -> the write lands; busy rises the next cycle; after the sweep, ra=7 reads INIT_VALUE.
